marquee_scroller: RTL
=====================

# marquee_scroller

Parametrised scrolling-text driver for multi-digit 7-segment displays; successor to the game's fixed 4-digit menu scroller. Selects one of a set of built-in messages by code, paces it with an internal tick divider, and presents it in scroll, static or blink mode on a packed segment bus. It sits between the game state machine, which supplies `msg_sel` and `mode`, and the display multiplexer.

## Interface
- `DIGITS`, 4: number of display digits; legal range 2..8.
- `SEG_W`, 7: bits per glyph.
- `TICK_DIV`, 9000000: clk cycles per scroll/blink tick; minimum 2.
- `GAP`, `DIGITS`: blank glyphs appended after each message pass, so the text fully exits before it repeats.
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `enable`  in  1: 0 forces a blank display and holds all counters at 0.
- `msg_sel`  in  3: message code (see Operation).
- `mode`  in  2: 0 = scroll, 1 = static, 2 = blink, 3 = treated as static.
- `display`  out  `DIGITS*SEG_W`: digit k occupies bits `[k*SEG_W +: SEG_W]`; digit `DIGITS-1` is leftmost.
- `wrap_pulse`  out  1: one-cycle pulse when a scroll pass completes.

## Operation
- Glyph codes: A=119, C=57, E=121, H=118, L=56, O=63, R=80, S=109, U=28, Y=110, W=29, I=25, N=84, P=115, G=111; blank=0.
- Messages and their lengths (LEN):
  - 0: empty, LEN 0.
  - 1: HOLA, LEN 4.
  - 2: CHOOSE HERO, LEN 11; the space is blank.
  - 3: GO, LEN 2.
  - 4: YOU WIN, LEN 7.
  - 5: PAUSE, LEN 5.
  - 6–7: empty.
- Tick generator: `tcnt` counts 0..`TICK_DIV-1` and wraps. `tick` is asserted on the cycle where `tcnt == TICK_DIV-1`.
- Latch: `msg_q` and `mode_q` register `msg_sel` and `mode`.
  - When either input differs from its latch: update the latch, clear `display`, and zero `idx`, `tcnt` and `phase`.
  - No tick is processed on that cycle.
- Scroll mode, on each tick:
  - `display` shifts one digit toward digit 0.
  - Digit `DIGITS-1` loads `glyph(idx)`, which is blank when `idx >= LEN`.
  - `idx` increments.
  - When `idx == LEN+GAP-1`, `idx` returns to 0 and `wrap_pulse` fires.
- Static mode: the digit showing text position j (j = 0 leftmost) holds `glyph(j)`, blank when j >= LEN. `idx` is unused.
- Blink mode: same content as static. `phase` toggles on each tick; when `phase=1` the whole display is blank.
- An empty message (LEN 0) leaves `display` blank, and `wrap_pulse` never fires.
- `enable=0`: `display=0`, `wrap_pulse=0`, all counters 0. The latches keep updating.
- Arithmetic: `idx` is `$clog2(16+GAP)` bits wide. LEN values are constants from the ROM, so `idx` never exceeds `LEN+GAP-1`.

## Timing
- Reset values: `display=0`, `wrap_pulse=0`, `tcnt=0`, `idx=0`, `phase=0`, `msg_q=0`, `mode_q=0`.
- Latency:
  - Outputs are registered; `display` changes on the clk edge that samples `tick`.
  - The first scroll glyph appears `TICK_DIV` cycles after a message change or reset release.
- `wrap_pulse` is high for exactly the one cycle on which `display` updates with the final gap shift.
- Priority when events coincide: `rst` > `enable=0` > latch change > tick.
- A `msg_sel` change on the same cycle as a tick: the tick is discarded and the display clears.
- `rst` asserted mid-scroll: all reset values apply on the next edge.

## Structure
- Package `disp_pkg`:
  - glyph code constants;
  - mode encodings `MODE_SCROLL`, `MODE_STATIC`, `MODE_BLINK`;
  - message code constants `MSG_OFF`, `MSG_HOLA`, `MSG_CHOOSE`, `MSG_GO`, `MSG_WIN`, `MSG_PAUSE`.
- Sub-module `msg_rom`: combinational; maps (`msg`, `pos`) to (`glyph`, `len`). It is shared with the static/blink path, which uses one `msg_rom` instance per digit position, or one instance walked by the position index.
- The top level holds the tick divider, the latches and the scroll/blink datapath.

## Test plan
All scenarios use `DIGITS=4`, `TICK_DIV=4`.
- Reset, then `msg_sel=1`, `mode=0`, `enable=1` -> after 4, 8, 12 and 16 cycles, `display[27:21]` = 118, 63, 56, 119 in turn. After 16 cycles `display` = {119, 56, 63, 118} (digit 3 down to digit 0). `wrap_pulse` fires at the 8th tick.
- `msg_sel=2` scroll for 15 ticks -> exactly one `wrap_pulse`, on tick 15. The 7th glyph shifted in is 0 (the space).
- `msg_sel=5`, `mode=2` -> `display` = {115, 119, 28, 109} on even ticks and 0 on odd ticks.
- Change `msg_sel` 1→3 mid-scroll, coincident with a tick -> `display=0` on the next cycle, `idx=0`, and the first G appears 4 cycles later.
- `enable` low for 10 cycles mid-scroll -> `display=0` and no `wrap_pulse`. After `enable` returns high, scrolling restarts from `idx=0`.
- `msg_sel=0` in every mode -> `display` stays 0 and `wrap_pulse` stays 0 for 100 cycles.

Source files
------------

// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - glyph, mode and message codes shared by the marquee scroller
// Glyph constants are 7-segment patterns; blank is all segments off.
package disp_pkg;

    localparam logic [6:0] G_BLANK = 7'd0;
    localparam logic [6:0] G_A     = 7'd119;
    localparam logic [6:0] G_C     = 7'd57;
    localparam logic [6:0] G_E     = 7'd121;
    localparam logic [6:0] G_H     = 7'd118;
    localparam logic [6:0] G_L     = 7'd56;
    localparam logic [6:0] G_O     = 7'd63;
    localparam logic [6:0] G_R     = 7'd80;
    localparam logic [6:0] G_S     = 7'd109;
    localparam logic [6:0] G_U     = 7'd28;
    localparam logic [6:0] G_Y     = 7'd110;
    localparam logic [6:0] G_W     = 7'd29;
    localparam logic [6:0] G_I     = 7'd25;
    localparam logic [6:0] G_N     = 7'd84;
    localparam logic [6:0] G_P     = 7'd115;
    localparam logic [6:0] G_G     = 7'd111;

    localparam logic [1:0] MODE_SCROLL = 2'd0;
    localparam logic [1:0] MODE_STATIC = 2'd1;
    localparam logic [1:0] MODE_BLINK  = 2'd2;

    localparam logic [2:0] MSG_OFF    = 3'd0;
    localparam logic [2:0] MSG_HOLA   = 3'd1;
    localparam logic [2:0] MSG_CHOOSE = 3'd2;
    localparam logic [2:0] MSG_GO     = 3'd3;
    localparam logic [2:0] MSG_WIN    = 3'd4;
    localparam logic [2:0] MSG_PAUSE  = 3'd5;

    // Longest message is 11 glyphs, so 4 bits of length and a 16-entry table suffice.
    localparam int LEN_W = 4;

endpackage

// File: rtl/msg_rom.sv
// rtl/msg_rom.sv - combinational message ROM: (message, position) -> (glyph, length)
// Positions at or beyond the message length read as blank; POS_W must be at least 4.
module msg_rom
    import disp_pkg::*;
#(
    parameter int SEG_W = 7,
    parameter int POS_W = 5
) (
    input  logic [2:0]       msg_i,
    input  logic [POS_W-1:0] pos_i,
    output logic [SEG_W-1:0] glyph_o,
    output logic [LEN_W-1:0] len_o
);

    logic [6:0] tbl [16];
    logic [6:0] g7;

    always_comb begin
        for (int i = 0; i < 16; i++) tbl[i] = G_BLANK;
        len_o = '0;
        case (msg_i)
            MSG_HOLA: begin
                len_o = 4'd4;
                tbl[0] = G_H; tbl[1] = G_O; tbl[2] = G_L; tbl[3] = G_A;
            end
            MSG_CHOOSE: begin
                len_o = 4'd11;
                tbl[0] = G_C; tbl[1] = G_H; tbl[2] = G_O; tbl[3] = G_O;
                tbl[4] = G_S; tbl[5] = G_E; tbl[6] = G_BLANK;
                tbl[7] = G_H; tbl[8] = G_E; tbl[9] = G_R; tbl[10] = G_O;
            end
            MSG_GO: begin
                len_o = 4'd2;
                tbl[0] = G_G; tbl[1] = G_O;
            end
            MSG_WIN: begin
                len_o = 4'd7;
                tbl[0] = G_Y; tbl[1] = G_O; tbl[2] = G_U; tbl[3] = G_BLANK;
                tbl[4] = G_W; tbl[5] = G_I; tbl[6] = G_N;
            end
            MSG_PAUSE: begin
                len_o = 4'd5;
                tbl[0] = G_P; tbl[1] = G_A; tbl[2] = G_U; tbl[3] = G_S; tbl[4] = G_E;
            end
            default: len_o = '0;
        endcase
        g7      = (pos_i < POS_W'(len_o)) ? tbl[pos_i[3:0]] : G_BLANK;
        glyph_o = SEG_W'(g7);
    end

endmodule

// File: rtl/marquee_scroller.sv
// rtl/marquee_scroller.sv - scrolling/static/blinking text driver for a multi-digit 7-segment bus
// Holds the tick divider, the message/mode latches and the display datapath.
module marquee_scroller
    import disp_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SEG_W    = 7,
    parameter int TICK_DIV = 9000000,
    parameter int GAP      = DIGITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [2:0]              msg_sel,
    input  logic [1:0]              mode,
    output logic [DIGITS*SEG_W-1:0] display,
    output logic                    wrap_pulse
);

    localparam int IDX_W  = $clog2(16 + GAP);
    localparam int TCNT_W = $clog2(TICK_DIV);
    localparam int DW     = DIGITS * SEG_W;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TICK_DIV - 1);

    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d, idx_last;
    logic              phase_q, phase_d;
    logic [2:0]        msg_q;
    logic [1:0]        mode_q;
    logic [DW-1:0]     disp_q, disp_d;
    logic              wrap_q, wrap_d;
    logic              tick, changed;

    logic [SEG_W-1:0]  scroll_glyph;
    logic [LEN_W-1:0]  scroll_len;
    logic [DW-1:0]     static_img;
    logic [LEN_W-1:0]  static_len_unused [DIGITS];

    msg_rom #(.SEG_W(SEG_W), .POS_W(IDX_W)) u_scroll_rom (
        .msg_i   (msg_q),
        .pos_i   (idx_q),
        .glyph_o (scroll_glyph),
        .len_o   (scroll_len)
    );

    // Text position j lands on digit DIGITS-1-j so the message reads left to right.
    for (genvar j = 0; j < DIGITS; j++) begin : g_static
        msg_rom #(.SEG_W(SEG_W), .POS_W(IDX_W)) u_static_rom (
            .msg_i   (msg_q),
            .pos_i   (IDX_W'(j)),
            .glyph_o (static_img[(DIGITS-1-j)*SEG_W +: SEG_W]),
            .len_o   (static_len_unused[j])
        );
    end

    assign tick     = (tcnt_q == TCNT_LAST);
    assign changed  = (msg_sel != msg_q) || (mode != mode_q);
    assign idx_last = IDX_W'(scroll_len) + IDX_W'(GAP - 1);

    always_comb begin
        tcnt_d  = tcnt_q;
        idx_d   = idx_q;
        phase_d = phase_q;
        disp_d  = disp_q;
        wrap_d  = 1'b0;
        if (!enable || changed) begin
            tcnt_d  = '0;
            idx_d   = '0;
            phase_d = 1'b0;
            disp_d  = '0;
        end else begin
            tcnt_d = tick ? '0 : tcnt_q + TCNT_W'(1);
            if (tick) begin
                case (mode_q)
                    MODE_SCROLL: begin
                        disp_d = {scroll_glyph, disp_q[DW-1:SEG_W]};
                        if (idx_q == idx_last) begin
                            idx_d  = '0;
                            wrap_d = (scroll_len != '0);
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                    MODE_BLINK: begin
                        phase_d = ~phase_q;
                        disp_d  = phase_q ? static_img : '0;
                    end
                    default: disp_d = static_img;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q  <= '0;
            idx_q   <= '0;
            phase_q <= 1'b0;
            msg_q   <= '0;
            mode_q  <= '0;
            disp_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            tcnt_q  <= tcnt_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            msg_q   <= msg_sel;
            mode_q  <= mode;
            disp_q  <= disp_d;
            wrap_q  <= wrap_d;
        end
    end

    assign display    = disp_q;
    assign wrap_pulse = wrap_q;

endmodule
